// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes, default width.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package uart_pkg;

    // Payload bits per frame unless a parent overrides DATA_WIDTH.
    localparam int DATA_WIDTH_DEF = 8;

    // Parity type codes as they appear on PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame sequencer states; the RX side walks the same sequence.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Terminal value of the 6-bit edge counter for a given Prescale.
    // A Prescale of 0 is treated as 1 clk per bit, so the counter never
    // has to reach 63 and wrap through zero.
    function automatic logic [5:0] last_edge_of(input logic [5:0] presc);
        return (presc == 6'd0) ? 6'd0 : presc - 6'd1;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Parallel request side of the UART transmitter plus its serial/status outputs.
// Latency: none (wiring only).
// Backpressure: busy=1 means a request on Data_Valid is dropped, not queued.
interface uart_tx_if #(
    parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH_DEF
) ();

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic                  TX_OUT;
    logic                  busy;

    // Requester: drives the payload and frame options, watches line/busy.
    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output Prescale,
        input  TX_OUT,
        input  busy
    );

    // Transmitter: consumes the request, drives the line and busy.
    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  Prescale,
        output TX_OUT,
        output busy
    );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Parity bit for the latched payload: plain XOR for even, inverted for odd.
// Latency: combinational, 0 clk.
// Backpressure: none; output follows inputs continuously.
module parity_calc import uart_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    // Even parity makes the total count of ones even, odd makes it odd.
    always_comb begin
        parity = ^data;
        case (par_typ)
            PAR_EVEN: parity = ^data;
            PAR_ODD:  parity = ~(^data);
            default:  parity = ^data;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB first, optional parity, stop bit.
// Latency: TX_OUT falls and busy rises 1 clk after the accepting edge.
// Backpressure: requests while busy=1 are dropped; next accept is the first IDLE clk.
module uart_tx import uart_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    uart_state_e           state;
    uart_state_e           state_nxt;

    // Per-bit timing and position within the payload.
    logic [5:0]            edge_cnt;
    logic [5:0]            edge_cnt_nxt;
    logic [BCW-1:0]        bit_cnt;
    logic [BCW-1:0]        bit_cnt_nxt;

    // Frame parameters captured at accept; inputs are free to move afterwards.
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_nxt;
    logic                  par_en_q;
    logic                  par_en_nxt;
    logic                  par_typ_q;
    logic                  par_typ_nxt;
    logic [5:0]            presc_q;
    logic [5:0]            presc_nxt;

    // Registered outputs; their next values are derived from the next state
    // so the line changes on the same edge as the state.
    logic                  tx_out_q;
    logic                  tx_nxt;
    logic                  busy_q;
    logic                  busy_nxt;

    logic                  bit_done;
    logic                  parity_bit;

    assign bit_done = (edge_cnt == last_edge_of(presc_q));

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data    (data_q),
        .par_typ (par_typ_q),
        .parity  (parity_bit)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, latched frame parameters and registered line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            presc_q   <= '0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            edge_cnt  <= edge_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            data_q    <= data_nxt;
            par_en_q  <= par_en_nxt;
            par_typ_q <= par_typ_nxt;
            presc_q   <= presc_nxt;
            tx_out_q  <= tx_nxt;
            busy_q    <= busy_nxt;
        end
    end

    // Next state, counter advance, parameter capture and next line value.
    always_comb begin
        state_nxt    = state;
        edge_cnt_nxt = edge_cnt;
        bit_cnt_nxt  = bit_cnt;
        data_nxt     = data_q;
        par_en_nxt   = par_en_q;
        par_typ_nxt  = par_typ_q;
        presc_nxt    = presc_q;
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;

        // Every non-idle state spends exactly one bit period per bit.
        if (state != IDLE) begin
            edge_cnt_nxt = bit_done ? 6'd0 : edge_cnt + 6'd1;
        end

        case (state)
            IDLE: begin
                edge_cnt_nxt = 6'd0;
                bit_cnt_nxt  = '0;
                if (bus.Data_Valid) begin
                    data_nxt    = bus.P_DATA;
                    par_en_nxt  = bus.PAR_EN;
                    par_typ_nxt = bus.PAR_TYP;
                    presc_nxt   = bus.Prescale;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BCW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Line level for the state being entered; data_q is already valid
        // by the time DATA is entered because START lasts at least 1 clk.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = data_q[bit_cnt_nxt];
            PARITY:  tx_nxt = parity_bit;
            default: tx_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.TX_OUT = tx_out_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level model predicts each accepted frame.
// Latency: checks 1 clk accept latency and exact per-cycle line waveform.
// Backpressure: model drops requests while its own frame timer runs.
module tb_uart_tx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();

    uart_tx #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // ---------------- reference model (frame level) ----------------
    int              model_left = 0;
    int              accept_cnt = 0;
    logic [1023:0]   exp_wave_q[$];
    int              exp_len_q[$];
    logic [7:0]      exp_data_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_left = 0;
            exp_wave_q.delete();
            exp_len_q.delete();
            exp_data_q.delete();
        end else if (model_left > 0) begin
            model_left--;
        end else if (bus.Data_Valid) begin
            logic [7:0]    d;
            logic [10:0]   seq;
            logic [1023:0] w;
            int            p;
            int            nb;
            int            n;
            d  = bus.P_DATA;
            p  = (bus.Prescale == 6'd0) ? 1 : int'(bus.Prescale);
            seq = '0;
            seq[0] = 1'b0;
            for (int i = 0; i < 8; i++) seq[1 + i] = d[i];
            nb = 9;
            if (bus.PAR_EN) begin
                seq[nb] = (($countones(d) % 2) == 1) ^ bus.PAR_TYP;
                nb++;
            end
            seq[nb] = 1'b1;
            nb++;
            w = '0;
            n = 0;
            for (int k = 0; k < nb; k++)
                for (int c = 0; c < p; c++) begin
                    w[n] = seq[k];
                    n++;
                end
            exp_wave_q.push_back(w);
            exp_len_q.push_back(n);
            exp_data_q.push_back(d);
            model_left = n;
            accept_cnt++;
        end
    end

    // ---------------- monitor ----------------
    logic [1023:0] cap;
    int            cap_len = 0;
    bit            in_frame = 0;
    int            idle_run = 0;
    int            frames_seen = 0;
    int            gap_q[$];

    function automatic void finish_frame();
        logic [1023:0] w;
        int            len;
        logic [7:0]    d;
        int            bad;
        if (exp_len_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got a %0d clk frame, expected none", cap_len);
            return;
        end
        w   = exp_wave_q.pop_front();
        len = exp_len_q.pop_front();
        d   = exp_data_q.pop_front();
        check("busy_length", cap_len, len);
        bad = -1;
        for (int i = 0; i < len && i < cap_len && i < 1024; i++)
            if (bad < 0 && cap[i] !== w[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL frame_wave data=%02h: cycle %0d got %0b, expected %0b",
                     d, bad, cap[bad], w[bad]);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 0;
            cap_len  = 0;
            idle_run = 0;
        end else if (bus.busy) begin
            if (!in_frame) begin
                in_frame = 1;
                cap_len  = 0;
                frames_seen++;
                gap_q.push_back(idle_run);
            end
            if (cap_len < 1024) cap[cap_len] = bus.TX_OUT;
            cap_len++;
        end else begin
            check("idle_line", int'(bus.TX_OUT), 1);
            if (in_frame) begin
                in_frame = 0;
                idle_run = 0;
                finish_frame();
            end
            idle_run++;
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_model_idle();
        int guard = 0;
        while (model_left != 0 && guard < 5000) begin
            tick(1);
            guard++;
        end
        if (model_left != 0) check("model_idle_timeout", model_left, 0);
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        wait_model_idle();
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        tick(1);
        bus.Data_Valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        wait_model_idle();
        tick(3);
        while (exp_len_q.size() != 0 && guard < 2000) begin
            tick(1);
            guard++;
        end
        check("frames_pending", exp_len_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs;
        int acc0;
        rst            = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd8;
        tick(3);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_tx", int'(bus.TX_OUT), 1);
        rst = 1'b1;
        tick(2);

        // 0xA5, no parity, 8 clk/bit; also the 1-clk accept latency.
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        check("latency_busy", int'(bus.busy), 1);
        check("latency_tx", int'(bus.TX_OUT), 0);
        drain();

        // 0xA5 with even then odd parity at 16 clk/bit.
        send(8'hA5, 1'b1, 1'b0, 6'd16);
        send(8'hA5, 1'b1, 1'b1, 6'd16);
        drain();

        // Data_Valid held across three frames with payload churning.
        wait_model_idle();
        gap_q.delete();
        acc0 = accept_cnt;
        bus.PAR_EN     = 1'b0;
        bus.Prescale   = 6'd8;
        bus.Data_Valid = 1'b1;
        for (int g = 0; g < 1000 && accept_cnt < acc0 + 3; g++) begin
            bus.P_DATA = 8'($urandom);
            tick(1);
        end
        bus.Data_Valid = 1'b0;
        drain();
        check("b2b_frames", gap_q.size(), 3);
        if (gap_q.size() >= 3) begin
            check("b2b_gap1", gap_q[1], 1);
            check("b2b_gap2", gap_q[2], 1);
        end

        // Request during DATA of a 0xFF frame is dropped.
        fs = frames_seen;
        send(8'hFF, 1'b0, 1'b0, 6'd8);
        tick(8 + 3 * 8);
        bus.P_DATA     = 8'h3C;
        bus.Data_Valid = 1'b1;
        tick(1);
        bus.Data_Valid = 1'b0;
        drain();
        tick(5);
        check("dropped_request", frames_seen - fs, 1);

        // Reset during data bit 4 aborts the frame for good.
        send(8'($urandom), 1'b0, 1'b0, 6'd8);
        tick(8 + 4 * 8 + 3);
        rst = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_tx", int'(bus.TX_OUT), 1);
        tick(3);
        rst = 1'b1;
        fs = frames_seen;
        tick(60);
        check("no_resume_busy", int'(bus.busy), 0);
        check("no_resume_frames", frames_seen - fs, 0);
        send(8'h5A, 1'b1, 1'b1, 6'd4);
        drain();

        // Prescale moves mid-frame; only the next frame sees it.
        send(8'h96, 1'b0, 1'b0, 6'd8);
        tick(20);
        bus.Prescale = 6'd32;
        bus.P_DATA   = 8'h00;
        bus.PAR_EN   = 1'b1;
        wait_model_idle();
        bus.Data_Valid = 1'b1;
        tick(1);
        bus.Data_Valid = 1'b0;
        drain();

        // Largest bit period.
        send(8'hC3, 1'b1, 1'b0, 6'd63);
        drain();

        // Random traffic with inputs moving every clk.
        for (int i = 0; i < 3000; i++) begin
            bus.P_DATA     = 8'($urandom);
            bus.PAR_EN     = 1'($urandom);
            bus.PAR_TYP    = 1'($urandom);
            bus.Prescale   = ($urandom_range(0, 19) == 0) ? 6'd63 : 6'($urandom_range(0, 10));
            bus.Data_Valid = ($urandom_range(0, 5) == 0);
            tick(1);
        end
        bus.Data_Valid = 1'b0;
        drain();
        tick(5);
        check("final_busy", int'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port clk  input  1  oversampled system clock, the same clock as the receiver.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload.
REQ-005 SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  parity bit enable.
REQ-007 SHALL have port PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-008 SHALL have port Prescale  input  6  clk cycles per bit, the same meaning as on the receiver side.
REQ-009 SHALL have port TX_OUT  output  1  serial line, registered, idle high.
REQ-010 SHALL have port busy  output  1  frame in progress, registered.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-012 SHALL, in IDLE with Data_Valid=1 at a clk edge, latch P_DATA, PAR_EN, PAR_TYP and Prescale, and go to START.
REQ-013 SHALL drive TX_OUT=0 and busy=1 from the first cycle after the accepting edge (latency 1 clk).
REQ-014 SHALL hold each bit (start, data, parity, stop) for exactly P clk cycles, where P = latched Prescale, or P = 1 when latched Prescale is 0.
REQ-015 SHALL transmit data LSB first, DATA_WIDTH bits, using a bit counter that advances once per bit period.
REQ-016 SHALL insert PARITY after DATA only when latched PAR_EN=1; otherwise DATA goes directly to STOP.
REQ-017 SHALL compute the parity bit as XOR of the latched data for even parity, and its inverse for odd parity.
REQ-018 SHALL drive TX_OUT=1 for the stop bit, then return to IDLE with busy=0 and TX_OUT=1.
REQ-019 SHALL keep busy high for exactly P*(DATA_WIDTH+2+PAR_EN) cycles per frame.
REQ-020 SHALL ignore Data_Valid while busy=1; no queuing.
REQ-021 SHALL not let changes on P_DATA, PAR_EN, PAR_TYP or Prescale during a frame affect that frame.
REQ-022 SHALL accept a request in the first IDLE cycle after STOP, giving a minimum inter-frame gap of 1 clk at TX_OUT=1.
REQ-023 SHALL wrap the edge counter (6-bit) to 0 at P-1; the counter SHALL never exceed 63.

Reset
REQ-024 SHALL, on rst=0 at any time including mid-frame, immediately force state=IDLE, TX_OUT=1, busy=0, and clear all counters and latched registers.
REQ-025 SHALL require a new Data_Valid in IDLE after rst deasserts before a frame starts; an aborted frame SHALL never resume.

Structure
REQ-026 SHALL place the FSM state encoding, the PAR_TYP constants (EVEN=0, ODD=1) and the DATA_WIDTH default in shared package uart_pkg, used by both RX and TX.
REQ-027 SHALL instantiate one sub-module, parity_calc (latched data + PAR_TYP -> parity bit, combinational); bit timing and the FSM stay in uart_tx.

Verification
REQ-028 SHALL cover: P_DATA=0xA5, PAR_EN=0, Prescale=8 -> TX_OUT = 0,1,0,1,0,0,1,0,1,1, each for 8 clk; busy high for 80 clk.
REQ-029 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 then PAR_TYP=1, Prescale=16 -> parity bit 0 then 1; busy high for 176 clk each frame.
REQ-030 SHALL cover: Data_Valid held high for 3 frames, Prescale=8, PAR_EN=0 -> frames separated by exactly 1 idle clk at TX_OUT=1, with no corruption.
REQ-031 SHALL cover: Data_Valid pulse with P_DATA=0x3C during the DATA state of a 0xFF frame -> 0xFF sent intact and 0x3C never sent.
REQ-032 SHALL cover: rst pulse during bit 4 of a frame -> TX_OUT=1 and busy=0 immediately; the next frame starts only after a new Data_Valid.
REQ-033 SHALL cover: Prescale changed from 8 to 32 mid-frame -> current frame keeps 8 clk per bit and the next frame uses 32.
